exp_shift_add: RTL and testbench

- Iterative shift-and-add exponential engine: computes y ≈ e^x for unsigned fixed-point x.
- Range reduction: integer phase uses k·ln2 steps; fractional phase uses ln(1+2^-i) steps.
- Parametrised in input and output width and iteration count; start/busy/done handshake and overflow saturation.
- Sits behind the per-step multiplier/subtractor generator, replacing the external iteration control with a self-sequenced datapath.

---
 rtl/exp_shift_add.sv | 146 ++++++++++++++
 tb/tb_exp_shift_add.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/exp_shift_add.sv
// rtl/exp_shift_add.sv - iterative shift-and-add e^x engine with overflow saturation
module exp_shift_add #(
  parameter  int INT_W     = 4,
  parameter  int FRAC_W    = 11,
  parameter  int OUT_INT_W = 16,
  parameter  int N_FRA     = 10,
  localparam int X_W       = INT_W + FRAC_W,
  localparam int Y_W       = OUT_INT_W + FRAC_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [X_W-1:0] x,
  output logic           busy,
  output logic           done,
  output logic [Y_W-1:0] y,
  output logic [X_W-1:0] r,
  output logic           ovf
);

  localparam int SB = $clog2(OUT_INT_W);
  localparam int JW = (SB > 1) ? $clog2(SB) : 1;
  localparam int IW = $clog2(N_FRA + 1);

  function automatic int ci_val(input int j);
    real v;
    v = 0.6931471805599453;
    for (int k = 0; k < j + FRAC_W; k++) v = v * 2.0;
    return $rtoi(v);
  endfunction

  // ln(1+t) by its alternating series; t <= 0.5 so 80 terms is far below 1 LSB
  function automatic int cf_val(input int i);
    real t, p, s, sc;
    t = 1.0;
    for (int k = 0; k < i; k++) t = t / 2.0;
    sc = 1.0;
    for (int k = 0; k < FRAC_W; k++) sc = sc * 2.0;
    p = t;
    s = 0.0;
    for (int n = 1; n <= 80; n++) begin
      if (n % 2 == 1) s = s + p / $itor(n);
      else            s = s - p / $itor(n);
      p = p * t;
    end
    return $rtoi(s * sc);
  endfunction

  logic [X_W-1:0] ci_tab [2**JW];
  logic [X_W-1:0] cf_tab [2**IW];

  for (genvar g = 0; g < 2**JW; g++) begin : g_ci
    assign ci_tab[g] = (g < SB) ? X_W'(ci_val(g)) : '0;
  end

  for (genvar g = 0; g < 2**IW; g++) begin : g_cf
    assign cf_tab[g] = (g >= 1 && g <= N_FRA) ? X_W'(cf_val(g)) : '0;
  end

  typedef enum logic [1:0] {S_IDLE, S_INT, S_FRA, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [JW-1:0]  j_q, j_d;
  logic [IW-1:0]  i_q, i_d;
  logic [X_W-1:0] r_q, r_d, r_step;
  logic [Y_W-1:0] y_q, y_d;
  logic           ovf_q, ovf_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      j_q     <= '0;
      i_q     <= '0;
      r_q     <= '0;
      y_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      i_q     <= i_d;
      r_q     <= r_d;
      y_q     <= y_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    i_d     = i_q;
    r_d     = r_q;
    y_d     = y_q;
    ovf_d   = ovf_q;
    r_step  = r_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          r_d     = x;
          y_d     = Y_W'(1) << FRAC_W;
          ovf_d   = 1'b0;
          j_d     = JW'(SB - 1);
          i_d     = IW'(1);
          state_d = S_INT;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_INT: begin
        if (r_q >= ci_tab[j_q]) begin
          r_step = r_q - ci_tab[j_q];
          y_d    = y_q << (32'd1 << j_q);
        end
        r_d = r_step;
        // a residual still >= ln2 after the last step means e^x exceeds Y_W bits
        if (j_q == JW'(0)) begin
          if (r_step >= ci_tab[JW'(0)]) begin
            ovf_d   = 1'b1;
            y_d     = '1;
            state_d = S_DONE;
          end else begin
            i_d     = IW'(1);
            state_d = S_FRA;
          end
        end else begin
          j_d = j_q - 1'b1;
        end
      end
      S_FRA: begin
        if (r_q >= cf_tab[i_q]) begin
          r_d = r_q - cf_tab[i_q];
          y_d = y_q + (y_q >> i_q);
        end
        if (i_q == IW'(N_FRA)) state_d = S_DONE;
        else                   i_d = i_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q == S_INT) || (state_q == S_FRA);
  assign done = (state_q == S_DONE);
  assign y    = y_q;
  assign r    = r_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_exp_shift_add.sv
// tb/tb_exp_shift_add.sv - scoreboard bench for exp_shift_add against a real-valued ln model
module tb_exp_shift_add;

  localparam int F   = 11;
  localparam int SB  = 4;
  localparam int NF  = 10;
  localparam int XW  = 15;
  localparam int YW  = 27;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [XW-1:0] x = '0;
  logic          busy, done, ovf;
  logic [YW-1:0] y;
  logic [XW-1:0] r;

  typedef struct {
    longint y;
    longint r;
    longint ovf;
    int     lat;
    int     acc;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  exp_shift_add dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x     (x),
    .busy  (busy),
    .done  (done),
    .y     (y),
    .r     (r),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // e^x = 2^k * prod(1+2^-i): greedy subtraction of ln-valued constants
  function automatic exp_t model(input int xv, input int acc);
    exp_t   e;
    longint rr, yy, c;
    int     sh;
    rr = xv;
    sh = 0;
    for (int j = SB - 1; j >= 0; j--) begin
      c = $rtoi($pow(2.0, j) * $ln(2.0) * $pow(2.0, F));
      if (rr >= c) begin
        rr -= c;
        sh += 2 ** j;
      end
    end
    e.acc = acc;
    if (rr >= $rtoi($ln(2.0) * $pow(2.0, F))) begin
      e.y   = (longint'(1) << YW) - 1;
      e.r   = rr;
      e.ovf = 1;
      e.lat = SB + 1;
      return e;
    end
    yy = longint'(1) << (F + sh);
    for (int i = 1; i <= NF; i++) begin
      c = $rtoi($ln(1.0 + $pow(2.0, -i)) * $pow(2.0, F));
      if (rr >= c) begin
        rr -= c;
        yy = yy + (yy >> i);
      end
    end
    e.y   = yy;
    e.r   = rr;
    e.ovf = 0;
    e.lat = SB + NF + 1;
    return e;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("y", y, e.y);
          chk("r", r, e.r);
          chk("ovf", ovf, e.ovf);
          chk("latency", cyc - e.acc + 1, e.lat);
        end
      end
    end
  end

  task automatic issue(input int xv);
    int n;
    bit ok;
    n  = 0;
    ok = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      start = 1'b1;
      x     = XW'(xv);
      if (!busy) begin
        ok = 1;
        sb_q.push_back(model(xv, cyc + 1));
      end
      n++;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (sb_q.size() != 0) begin
      chk("done_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_y"}, y, 0);
    chk({tag, "_r"}, r, 0);
    chk({tag, "_ovf"}, ovf, 0);
  endtask

  initial begin : stim
    int xv;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    issue(0);
    drain();
    issue(2048);
    drain();
    chk("y_1p0", y, 5578);
    issue(22528);
    drain();
    chk("y_11p0_top_bit", y[YW-1], 1);
    issue(24576);
    drain();
    chk("y_12p0_sat", y, (1 << 27) - 1);

    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      start = 1'b1;
      x     = XW'(2048);
      if (!busy) sb_q.push_back(model(2048, cyc + 1));
    end
    @(negedge clk);
    start = 1'b0;
    drain();

    issue(2048);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    sb_q.delete();
    @(posedge clk);
    #1;
    chk_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    issue(2048);
    drain();

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 1) == 1) xv = int'($urandom_range(0, 22713));
      else                           xv = int'($urandom_range(0, 32767));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(xv);
    end
    drain();

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
